// File: rtl/mm_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mm_game_pkg
//  Description : Shared types for the multi-mode counter game.
//                ctrl_e  - counter step command encoding
//                who_e   - game-result encoding on the who output
//                state_e - PLAY/END game state
//  Revision    : 1.0 - initial release
// ============================================================================
package mm_game_pkg;

    typedef enum logic [1:0] {
        UP1 = 2'b00,
        UP2 = 2'b01,
        DN1 = 2'b10,
        DN2 = 2'b11
    } ctrl_e;

    typedef enum logic [1:0] {
        WHO_NONE   = 2'b00,
        WHO_LOSER  = 2'b01,
        WHO_WINNER = 2'b10
    } who_e;

    typedef enum logic [0:0] {
        PLAY = 1'b0,
        END  = 1'b1
    } state_e;

endpackage : mm_game_pkg
`default_nettype wire

// File: rtl/mm_score_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mm_score_counter
//  Description : Saturating tally for one kind of game event.
//                Increments on i_inc, clears on i_clr, never exceeds LIMIT.
//                o_hit flags that the increment being applied this cycle
//                brings the tally to LIMIT.
//  Ports       : clk, rst (sync, active-high), i_inc, i_clr,
//                o_score [SCORE_W], o_hit
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_score_counter #(
    parameter int SCORE_W = 4,
    parameter int LIMIT   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc,
    input  logic               i_clr,
    output logic [SCORE_W-1:0] o_score,
    output logic               o_hit
);

    localparam logic [SCORE_W-1:0] c_LIMIT    = SCORE_W'(LIMIT);
    localparam logic [SCORE_W-1:0] c_LIMIT_M1 = SCORE_W'(LIMIT - 1);

    logic [SCORE_W-1:0] r_score;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_score <= '0;
        end else if (i_clr) begin
            r_score <= '0;
        end else if (i_inc && (r_score != c_LIMIT)) begin
            r_score <= r_score + SCORE_W'(1);
        end
    end

    assign o_score = r_score;
    assign o_hit   = i_inc && !i_clr && (r_score == c_LIMIT_M1);

endmodule : mm_score_counter
`default_nettype wire

// File: rtl/mm_game_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mm_game_engine
//  Description : Multi-mode counter game. A WIDTH-bit up/down counter steps
//                by 1 or 2 (or a programmable step), pulses winner/loser on
//                writing all-ones/all-zeros, tallies the pulses and ends a
//                game (gameover/who) when a tally reaches LIMIT, after which
//                all play state restarts.
//  Options     : MM_PROG_STEP_EN - adds the 'step' input; ctrl[0]=1 then
//                steps by 'step' instead of 2 (step=0 holds).
//  Ports       : clk, rst (sync, active-high), en, ctrl[2], init,
//                init_val[WIDTH], [step[WIDTH]], count[WIDTH], winner,
//                loser, w_score[SCORE_W], l_score[SCORE_W], gameover,
//                who[2], games[8]
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_game_engine
    import mm_game_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SCORE_W = 4,
    parameter int LIMIT   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         ctrl,
    input  logic               init,
    input  logic [WIDTH-1:0]   init_val,
`ifdef MM_PROG_STEP_EN
    input  logic [WIDTH-1:0]   step,
`endif
    output logic [WIDTH-1:0]   count,
    output logic               winner,
    output logic               loser,
    output logic [SCORE_W-1:0] w_score,
    output logic [SCORE_W-1:0] l_score,
    output logic               gameover,
    output logic [1:0]         who,
    output logic [7:0]         games
);

    localparam logic [WIDTH-1:0]   c_MID   = WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic [SCORE_W-1:0] c_LIMIT = SCORE_W'(LIMIT);

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_next;
    logic [WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]   w_stepped;
    logic               w_write;
    logic               r_winner;
    logic               r_loser;
    logic               w_clear;
    logic               w_winner;
    logic               w_loser;
    logic               w_w_hit;
    logic               w_l_hit;
    logic [SCORE_W-1:0] w_w_score;
    logic [SCORE_W-1:0] w_l_score;
    logic [7:0]         r_games;
    who_e               w_who;
    ctrl_e              w_ctrl;

    // The END cycle is the restart cycle: its closing edge clears play state.
    assign w_clear = (r_state == END);
    assign w_ctrl  = ctrl_e'(ctrl);

`ifdef MM_PROG_STEP_EN
    assign w_step = ((w_ctrl == UP2) || (w_ctrl == DN2)) ? step : WIDTH'(1);
`else
    assign w_step = ((w_ctrl == UP2) || (w_ctrl == DN2)) ? WIDTH'(2) : WIDTH'(1);
`endif

    // Modulo 2**WIDTH arithmetic: wrap-around is intentional.
    assign w_stepped = ((w_ctrl == DN1) || (w_ctrl == DN2)) ? (r_count - w_step)
                                                            : (r_count + w_step);

    // Count update; w_write marks edges that load a new value into count,
    // which is what qualifies a winner/loser pulse (a zero step is a hold).
    always_comb begin
        w_count_next = r_count;
        w_write      = 1'b0;
        if (w_clear) begin
            w_count_next = c_MID;
        end else if (init) begin
            w_count_next = init_val;
            w_write      = 1'b1;
        end else if (en && (w_step != '0)) begin
            w_count_next = w_stepped;
            w_write      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= c_MID;
            r_winner <= 1'b0;
            r_loser  <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            r_winner <= w_write && (w_count_next == '1);
            r_loser  <= w_write && (w_count_next == '0);
        end
    end

    // A pulse landing in the END cycle is suppressed; tallies clear anyway.
    assign w_winner = r_winner && !w_clear;
    assign w_loser  = r_loser  && !w_clear;

    mm_score_counter #(
        .SCORE_W (SCORE_W),
        .LIMIT   (LIMIT)
    ) u_w_score (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_winner),
        .i_clr   (w_clear),
        .o_score (w_w_score),
        .o_hit   (w_w_hit)
    );

    mm_score_counter #(
        .SCORE_W (SCORE_W),
        .LIMIT   (LIMIT)
    ) u_l_score (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_loser),
        .i_clr   (w_clear),
        .o_score (w_l_score),
        .o_hit   (w_l_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PLAY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PLAY:    if (w_w_hit || w_l_hit) w_state_next = END;
            END:     w_state_next = PLAY;
            default: w_state_next = PLAY;
        endcase
    end

    always_comb begin
        w_who = WHO_NONE;
        if (w_clear) begin
            if (w_w_score == c_LIMIT) begin
                w_who = WHO_WINNER;
            end else if (w_l_score == c_LIMIT) begin
                w_who = WHO_LOSER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_games <= 8'd0;
        end else if (w_clear) begin
            r_games <= r_games + 8'd1;
        end
    end

    assign count    = r_count;
    assign winner   = w_winner;
    assign loser    = w_loser;
    assign w_score  = w_w_score;
    assign l_score  = w_l_score;
    assign gameover = w_clear;
    assign who      = w_who;
    assign games    = r_games;

endmodule : mm_game_engine
`default_nettype wire

// File: tb/tb_mm_game_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mm_game_engine
//  Description : Self-checking bench for mm_game_engine (WIDTH=4, LIMIT=15).
//                Table of single-cycle vectors plus hand-written game
//                sequences for gameover, restart and reset-in-END.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_game_engine;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [1:0] ctrl;
        logic       init;
        logic [3:0] iv;
        logic [3:0] cnt;
        logic       win;
        logic       los;
        logic [3:0] ws;
        logic [3:0] ls;
        logic       go;
        logic [1:0] who;
        logic [7:0] games;
    } vec_t;

    localparam int NV = 26;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] ctrl = 2'b00;
    logic       init = 1'b0;
    logic [3:0] init_val = 4'd0;
`ifdef MM_PROG_STEP_EN
    logic [3:0] step = 4'd2;
`endif
    logic [3:0] count;
    logic       winner;
    logic       loser;
    logic [3:0] w_score;
    logic [3:0] l_score;
    logic       gameover;
    logic [1:0] who;
    logic [7:0] games;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    mm_game_engine #(
        .WIDTH   (4),
        .SCORE_W (4),
        .LIMIT   (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ctrl     (ctrl),
        .init     (init),
        .init_val (init_val),
`ifdef MM_PROG_STEP_EN
        .step     (step),
`endif
        .count    (count),
        .winner   (winner),
        .loser    (loser),
        .w_score  (w_score),
        .l_score  (l_score),
        .gameover (gameover),
        .who      (who),
        .games    (games)
    );

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] c,
                                input logic i, input logic [3:0] v,
                                input logic [3:0] cn, input logic w, input logic l,
                                input logic [3:0] wsc, input logic [3:0] lsc,
                                input logic g, input logic [1:0] wh, input logic [7:0] gm);
        vec_t t;
        t.rst = r;  t.en = e;  t.ctrl = c;  t.init = i;  t.iv = v;
        t.cnt = cn; t.win = w; t.los = l;   t.ws = wsc;  t.ls = lsc;
        t.go = g;   t.who = wh; t.games = gm;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] c,
                         input logic i, input logic [3:0] v);
        rst = r; en = e; ctrl = c; init = i; init_val = v;
    endtask

    // Plays one game by reloading the same extreme every cycle; stops with
    // the DUT in its END cycle and checks every cycle on the way.
    task automatic play_game(input logic [3:0] extreme, input logic [7:0] g_before);
        drive(1'b0, 1'b0, 2'b00, 1'b1, extreme);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("game_count", int'(count), int'(extreme));
            if (extreme == 4'd15) begin
                chk("game_winner", int'(winner), (k < 16) ? 1 : 0);
                chk("game_wscore", int'(w_score), k - 1);
            end else begin
                chk("game_loser", int'(loser), (k < 16) ? 1 : 0);
                chk("game_lscore", int'(l_score), k - 1);
            end
            chk("game_gameover", int'(gameover), (k == 16) ? 1 : 0);
            chk("game_who", int'(who), (k == 16) ? ((extreme == 4'd15) ? 2 : 1) : 0);
            chk("game_games", int'(games), int'(g_before));
        end
    endtask

    initial begin
        // ---------------- vector table ----------------
        vecs[0] = mk(1, 0, 2'd0, 0, 4'd0,  4'd7,  0, 0, 4'd0, 4'd0, 0, 2'd0, 8'd0);
        for (int i = 1; i <= 7; i++)
            vecs[i] = mk(0, 1, 2'd0, 0, 4'd0, 4'(7 + i), 0, 0, 4'd0, 4'd0, 0, 2'd0, 8'd0);
        vecs[8]  = mk(0, 1, 2'd0, 0, 4'd0,  4'd15, 1, 0, 4'd0, 4'd0, 0, 2'd0, 8'd0);
        vecs[9]  = mk(0, 0, 2'd0, 0, 4'd0,  4'd15, 0, 0, 4'd1, 4'd0, 0, 2'd0, 8'd0);
        vecs[10] = mk(0, 0, 2'd0, 1, 4'd0,  4'd0,  0, 1, 4'd1, 4'd0, 0, 2'd0, 8'd0);
        vecs[11] = mk(0, 0, 2'd0, 0, 4'd0,  4'd0,  0, 0, 4'd1, 4'd1, 0, 2'd0, 8'd0);
        vecs[12] = mk(0, 0, 2'd0, 0, 4'd0,  4'd0,  0, 0, 4'd1, 4'd1, 0, 2'd0, 8'd0);
        vecs[13] = mk(0, 0, 2'd0, 0, 4'd0,  4'd0,  0, 0, 4'd1, 4'd1, 0, 2'd0, 8'd0);
        vecs[14] = mk(0, 0, 2'd0, 1, 4'd14, 4'd14, 0, 0, 4'd1, 4'd1, 0, 2'd0, 8'd0);
        vecs[15] = mk(0, 1, 2'd1, 0, 4'd0,  4'd0,  0, 1, 4'd1, 4'd1, 0, 2'd0, 8'd0);
        vecs[16] = mk(0, 0, 2'd0, 1, 4'd1,  4'd1,  0, 0, 4'd1, 4'd2, 0, 2'd0, 8'd0);
        vecs[17] = mk(0, 1, 2'd3, 0, 4'd0,  4'd15, 1, 0, 4'd1, 4'd2, 0, 2'd0, 8'd0);
        vecs[18] = mk(0, 0, 2'd0, 1, 4'd13, 4'd13, 0, 0, 4'd2, 4'd2, 0, 2'd0, 8'd0);
        vecs[19] = mk(0, 1, 2'd1, 0, 4'd0,  4'd15, 1, 0, 4'd2, 4'd2, 0, 2'd0, 8'd0);
        vecs[20] = mk(0, 1, 2'd1, 0, 4'd0,  4'd1,  0, 0, 4'd3, 4'd2, 0, 2'd0, 8'd0);
        vecs[21] = mk(0, 0, 2'd0, 1, 4'd15, 4'd15, 1, 0, 4'd3, 4'd2, 0, 2'd0, 8'd0);
        vecs[22] = mk(0, 0, 2'd0, 1, 4'd15, 4'd15, 1, 0, 4'd4, 4'd2, 0, 2'd0, 8'd0);
        vecs[23] = mk(0, 0, 2'd0, 0, 4'd0,  4'd15, 0, 0, 4'd5, 4'd2, 0, 2'd0, 8'd0);
        vecs[24] = mk(0, 1, 2'd2, 0, 4'd0,  4'd14, 0, 0, 4'd5, 4'd2, 0, 2'd0, 8'd0);
        vecs[25] = mk(0, 0, 2'd0, 0, 4'd0,  4'd14, 0, 0, 4'd5, 4'd2, 0, 2'd0, 8'd0);

        #2;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].ctrl, vecs[i].init, vecs[i].iv);
            tick();
            chk("vec_count",    int'(count),    int'(vecs[i].cnt));
            chk("vec_winner",   int'(winner),   int'(vecs[i].win));
            chk("vec_loser",    int'(loser),    int'(vecs[i].los));
            chk("vec_w_score",  int'(w_score),  int'(vecs[i].ws));
            chk("vec_l_score",  int'(l_score),  int'(vecs[i].ls));
            chk("vec_gameover", int'(gameover), int'(vecs[i].go));
            chk("vec_who",      int'(who),      int'(vecs[i].who));
            chk("vec_games",    int'(games),    int'(vecs[i].games));
        end

`ifdef MM_PROG_STEP_EN
        // Programmable step: 12 + 3 = 15 pulses winner; step 0 holds.
        drive(0, 0, 2'd0, 1, 4'd12);
        tick();
        chk("prog_load", int'(count), 12);
        drive(0, 1, 2'd1, 0, 4'd0);
        step = 4'd3;
        tick();
        chk("prog_step3_count",  int'(count),  15);
        chk("prog_step3_winner", int'(winner), 1);
        step = 4'd0;
        tick();
        chk("prog_step0_count",  int'(count),  15);
        chk("prog_step0_winner", int'(winner), 0);
        step = 4'd2;
`endif

        // ---------------- loser game ----------------
        drive(1, 0, 2'd0, 0, 4'd0);
        tick();
        chk("rst_count", int'(count), 7);
        chk("rst_games", int'(games), 0);
        play_game(4'd0, 8'd0);
        drive(0, 0, 2'd0, 0, 4'd0);
        tick();
        chk("lgame_after_count",    int'(count),    7);
        chk("lgame_after_lscore",   int'(l_score),  0);
        chk("lgame_after_gameover", int'(gameover), 0);
        chk("lgame_after_who",      int'(who),      0);
        chk("lgame_after_games",    int'(games),    1);

        // ---------------- winner game, init held through END ----------------
        play_game(4'd15, 8'd1);
        tick();
        chk("wgame_after_count",  int'(count),   7);
        chk("wgame_after_winner", int'(winner),  0);
        chk("wgame_after_wscore", int'(w_score), 0);
        chk("wgame_after_who",    int'(who),     0);
        chk("wgame_after_games",  int'(games),   2);
        tick();
        chk("wgame_replay_count",  int'(count),  15);
        chk("wgame_replay_winner", int'(winner), 1);

        // ---------------- reset during END ----------------
        drive(1, 0, 2'd0, 0, 4'd0);
        tick();
        drive(0, 0, 2'd0, 0, 4'd0);
        tick();
        chk("pre_rst_games", int'(games), 0);
        // Build games back up to 1 first so the reset is visible on it.
        play_game(4'd0, 8'd0);
        drive(0, 0, 2'd0, 0, 4'd0);
        tick();
        chk("pre_rst_games1", int'(games), 1);
        play_game(4'd0, 8'd1);
        drive(1, 0, 2'd0, 0, 4'd0);
        tick();
        chk("rst_end_count",    int'(count),    7);
        chk("rst_end_games",    int'(games),    0);
        chk("rst_end_gameover", int'(gameover), 0);
        chk("rst_end_lscore",   int'(l_score),  0);
        drive(0, 0, 2'd0, 0, 4'd0);
        tick();
        chk("rst_end_no_repeat", int'(gameover), 0);
        chk("rst_end_games2",    int'(games),    0);
        chk("rst_end_count2",    int'(count),    7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mm_game_engine
`default_nettype wire
